// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and config-field helpers for the parametrised switch box
package sb_pkg;

    localparam int SIDES           = 4;
    localparam int CFG_WORD_W      = 32;
    localparam int FIELD_W         = 4;
    localparam int SEL_W           = 3;
    localparam int FIELDS_PER_WORD = 8;

    // One 4-bit field per output, eight fields per 32-bit config word.
    function automatic int num_words(input int tracks);
        return (SIDES * tracks) / FIELDS_PER_WORD;
    endfunction

    function automatic int field_word(input int o);
        return o / FIELDS_PER_WORD;
    endfunction

    function automatic int field_nib(input int o);
        return o % FIELDS_PER_WORD;
    endfunction

endpackage

// File: rtl/sb_out_cell.sv
// rtl/sb_out_cell.sv - one switch-box output: source mux, out-of-range zeroing, optional register
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   side_i     : candidate tracks from sides (s+1), (s+2), (s+3), WIDTH bits each
//   pe_i       : PE results, WIDTH bits each
//   sel_i      : source select (0..2 sides, 3.. PEs, beyond that zero)
//   reg_en_i   : 1 = drive the registered mux value, 0 = drive the mux directly
//   out_o      : output track
import sb_pkg::*;

module sb_out_cell #(
    parameter int WIDTH  = 1,
    parameter int NUM_PE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3*WIDTH-1:0]      side_i,
    input  logic [NUM_PE*WIDTH-1:0] pe_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic                    reg_en_i,
    output logic [WIDTH-1:0]        out_o
);

    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_reg_q;

    // Any select that matches no source falls through to the zero default.
    always_comb begin
        mux_d = '0;
        for (int k = 0; k < 3; k++) begin
            if (sel_i == SEL_W'(k)) begin
                mux_d = side_i[k*WIDTH +: WIDTH];
            end
        end
        for (int p = 0; p < NUM_PE; p++) begin
            if (sel_i == SEL_W'(3 + p)) begin
                mux_d = pe_i[p*WIDTH +: WIDTH];
            end
        end
    end

    // Registered copy runs every cycle so switching reg_en on picks up a current value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg_q <= '0;
        end else begin
            out_reg_q <= mux_d;
        end
    end

    assign out_o = reg_en_i ? out_reg_q : mux_d;

endmodule

// File: rtl/sb_param_staged.sv
// rtl/sb_param_staged.sv - parametrised switch box with shadow/active config, commit and readback
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   in_wire         : 4*TRACKS input tracks, side s track t at [(s*TRACKS+t)*WIDTH +: WIDTH]
//   out_wire        : 4*TRACKS output tracks, same packing
//   pe_output       : NUM_PE PE results, PE p at [p*WIDTH +: WIDTH]
//   config_addr     : config word index
//   config_data     : write data for the shadow word
//   config_en       : write strobe into shadow config
//   config_commit   : copy whole shadow into active config
//   config_rd_en    : readback request of shadow[config_addr]
//   config_rd_data  : readback data, valid the cycle after the request
//   config_rd_valid : readback valid
import sb_pkg::*;

module sb_param_staged #(
    parameter int TRACKS     = 4,
    parameter int WIDTH      = 1,
    parameter int NUM_PE     = 1,
    parameter int CFG_ADDR_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SIDES*TRACKS*WIDTH-1:0]  in_wire,
    output logic [SIDES*TRACKS*WIDTH-1:0]  out_wire,
    input  logic [NUM_PE*WIDTH-1:0]        pe_output,
    input  logic [CFG_ADDR_W-1:0]          config_addr,
    input  logic [CFG_WORD_W-1:0]          config_data,
    input  logic                           config_en,
    input  logic                           config_commit,
    input  logic                           config_rd_en,
    output logic [CFG_WORD_W-1:0]          config_rd_data,
    output logic                           config_rd_valid
);

    localparam int NUM_WORDS = num_words(TRACKS);

    logic [CFG_WORD_W-1:0] shadow_q [NUM_WORDS];
    logic [CFG_WORD_W-1:0] shadow_d [NUM_WORDS];
    logic [CFG_WORD_W-1:0] active_q [NUM_WORDS];
    logic [CFG_WORD_W-1:0] active_d [NUM_WORDS];
    logic [CFG_WORD_W-1:0] rd_data_q;
    logic [CFG_WORD_W-1:0] rd_data_d;
    logic                  rd_valid_q;
    logic                  rd_valid_d;

    // Commit and readback both look at shadow_q, so a same-cycle write is
    // invisible to them: commit takes the old shadow, readback returns the old word.
    // Addresses matching no word leave the shadow untouched and read back as zero.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = config_rd_en;
        if (config_commit) begin
            active_d = shadow_q;
        end
        if (config_rd_en) begin
            rd_data_d = '0;
        end
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (config_en && (config_addr == CFG_ADDR_W'(w))) begin
                shadow_d[w] = config_data;
            end
            if (config_rd_en && (config_addr == CFG_ADDR_W'(w))) begin
                rd_data_d = shadow_q[w];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                shadow_q[w] <= '0;
                active_q[w] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign config_rd_data  = rd_data_q;
    assign config_rd_valid = rd_valid_q;

    for (genvar s = 0; s < SIDES; s++) begin : g_side
        for (genvar t = 0; t < TRACKS; t++) begin : g_track
            localparam int O = s * TRACKS + t;
            localparam int W = field_word(O);
            localparam int N = field_nib(O);

            logic [FIELD_W-1:0] field;
            logic [3*WIDTH-1:0] sides;

            assign field = active_q[W][N*FIELD_W +: FIELD_W];

            // Disjoint topology: candidate k is side (s+k+1) on the same track index.
            for (genvar k = 0; k < 3; k++) begin : g_src
                assign sides[k*WIDTH +: WIDTH] =
                    in_wire[(((s + k + 1) % SIDES) * TRACKS + t) * WIDTH +: WIDTH];
            end

            sb_out_cell #(
                .WIDTH  (WIDTH),
                .NUM_PE (NUM_PE)
            ) u_cell (
                .clk      (clk),
                .reset    (reset),
                .side_i   (sides),
                .pe_i     (pe_output),
                .sel_i    (field[SEL_W-1:0]),
                .reg_en_i (field[FIELD_W-1]),
                .out_o    (out_wire[O*WIDTH +: WIDTH])
            );
        end
    end

endmodule
